// File: rtl/bcd_chrono.sv
// bcd_chrono: BCD stopwatch/timer with IDLE/RUN/PAUSE control, up/down counting and a terminal-count pulse.
// Define BCD_CHRONO_LAP_CAPTURE_EN to enable lap capture with a held display value.
module bcd_chrono #(
  parameter int NDIG    = 5,
  parameter int MSD_MAX = 5,
  parameter int WRAP    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic                lap,
  input  logic                dir,
  input  logic [4*NDIG-1:0]   load_val,
  output logic [4*NDIG-1:0]   count,
  output logic [4*NDIG-1:0]   disp,
  output logic [4*NDIG-1:0]   lap_val,
  output logic                running,
  output logic                tc
);

  localparam int         W       = 4 * NDIG;
  localparam logic [3:0] MSD_LIM = 4'(MSD_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  function automatic logic [3:0] digit_lim(input int i);
    return (i == NDIG - 1) ? MSD_LIM : 4'd9;
  endfunction

  function automatic logic [W-1:0] max_count();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = digit_lim(i);
    return v;
  endfunction

  localparam logic [W-1:0] MAX_COUNT = max_count();

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = v;
    for (int i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (d > digit_lim(i)) d = digit_lim(i);
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Ripple carry: a digit at its limit rolls to 0 and passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == digit_lim(i)) d = 4'd0;
        else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) d = digit_lim(i);
        else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  state_t         state, state_nxt;
  logic [W-1:0]   count_nxt, disp_nxt, lap_nxt, inc_val, dec_val;
  logic           term, running_nxt, tc_nxt, hold, hold_nxt;
  logic           at_max, at_zero;

  assign at_max  = (count == MAX_COUNT);
  assign at_zero = (count == '0);
  assign inc_val = bcd_inc(count);
  assign dec_val = bcd_dec(count);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      disp    <= '0;
      running <= 1'b0;
      tc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      disp    <= disp_nxt;
      running <= running_nxt;
      tc      <= tc_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    term      = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      if (state == RUN && tick) begin
        if (!dir) begin
          if (at_max) begin
            term = 1'b1;
            if (WRAP != 0) count_nxt = '0;
          end else begin
            count_nxt = inc_val;
          end
        end else if (at_zero) begin
          term = 1'b1;
        end else begin
          count_nxt = dec_val;
          term      = (dec_val == '0);
        end
      end
      // Only commands that are legal in the current state compete for priority.
      if (load && state != RUN)
        count_nxt = clamp_bcd(load_val);
      else if (start && state != RUN && !(dir && at_zero))
        state_nxt = RUN;
      else if (stop && state == RUN)
        state_nxt = PAUSE;
      if (term) begin
        if (dir)            state_nxt = IDLE;
        else if (WRAP == 0) state_nxt = PAUSE;
      end
    end
  end

  always_comb begin
    running_nxt = (state_nxt == RUN);
    tc_nxt      = term;
    hold_nxt    = hold;
    lap_nxt     = lap_val;
    if (clear) begin
      hold_nxt = 1'b0;
    end else if (lap) begin
      hold_nxt = ~hold;
      if (!hold) lap_nxt = count;
    end
    disp_nxt = hold_nxt ? lap_nxt : count_nxt;
  end

`ifdef BCD_CHRONO_LAP_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= 1'b0;
      lap_val <= '0;
    end else begin
      hold    <= hold_nxt;
      lap_val <= lap_nxt;
    end
  end
`else
  assign hold    = 1'b0;
  assign lap_val = '0;

  logic lap_unused;
  assign lap_unused = ^{lap, hold_nxt};
`endif

endmodule
